uart_tx_buffered: RTL and testbench

//   Buffered 8N1 UART transmitter, the transmit-side counterpart of the input subsystem's UART receiver.

---
 rtl/uart_tx_buffered.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : Buffered UART transmitter. Producers push bytes into a byte FIFO;
//            a frame FSM pops them and serialises each one LSB-first onto the
//            serial line at a fixed baud rate. Back-to-back queued bytes are
//            sent with no idle gap between frames.
// Options  : UART_TX_PARITY_EN - when defined, an even-parity bit is inserted
//            after the data bits (8E1). When undefined, the frame is 8N1.
// Ports    : clk          system clock, all logic on the rising edge
//            rst          synchronous reset, active-high
//            i_wr_en      push i_wr_data this cycle
//            i_wr_data    byte to transmit
//            o_full       FIFO holds FIFO_DEPTH bytes (registered)
//            o_empty      FIFO holds no bytes (registered)
//            o_fifo_cnt   bytes queued, excluding the byte in the shifter
//            o_overflow   1-cycle pulse after a write attempted while full
//            o_busy       frame in progress on the line
//            o_byte_done  1-cycle pulse on the last cycle of a stop bit
//            o_tx         serial line, idle high (registered)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic                          o_byte_done,
    output logic                          o_tx
);

    localparam int c_AW           = $clog2(FIFO_DEPTH);
    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    // Keep the baud counter at least one bit wide even for 1 clock per bit.
    localparam int c_CW           = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_BAUD_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_CNT_FULL  = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_cnt;
    logic [c_AW:0]   w_cnt_next;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic            w_wr_acc;
    logic            w_pop;
    logic [7:0]      w_rd_data;

    // Acceptance is judged on the registered full flag only, so a write that
    // coincides with a pop on a full FIFO is still dropped.
    assign w_wr_acc  = i_wr_en && !r_full;
    assign w_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_acc && !w_pop) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end else if (!w_wr_acc && w_pop) begin
            w_cnt_next = r_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_cnt      <= w_cnt_next;
            r_full     <= (w_cnt_next == c_CNT_FULL);
            r_empty    <= (w_cnt_next == '0);
            r_overflow <= i_wr_en && r_full;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [c_CW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_tx_next;
    logic            w_baud_clr;
    logic            w_shift_adv;
    logic            w_byte_done;
    logic            w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic            r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_rd_data;
        end
    end
`endif

    assign w_bit_end = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_bit_next   = r_bit;
        w_baud_clr   = 1'b0;
        w_pop        = 1'b0;
        w_shift_adv  = 1'b0;
        w_byte_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_ST_START;
                    w_tx_next    = 1'b0;
                    w_baud_clr   = 1'b1;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_next = c_ST_DATA;
                    w_tx_next    = r_shift[0];
                    w_bit_next   = 3'd0;
                    w_baud_clr   = 1'b1;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_clr = 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = c_ST_PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = c_ST_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        // The shifter moves right, so the next bit on the
                        // line is the one currently in position 1.
                        w_bit_next  = r_bit + 3'd1;
                        w_shift_adv = 1'b1;
                        w_tx_next   = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = c_ST_STOP;
                    w_tx_next    = 1'b1;
                    w_baud_clr   = 1'b1;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_byte_done = 1'b1;
                    w_baud_clr  = 1'b1;
                    if (!r_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        w_pop        = 1'b1;
                        w_state_next = c_ST_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = c_ST_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            if (w_baud_clr || (r_state == c_ST_IDLE)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + c_BAUD_ONE;
            end
            if (w_pop) begin
                r_shift <= w_rd_data;
            end else if (w_shift_adv) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_fifo_cnt  = r_cnt;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state != c_ST_IDLE);
    assign o_byte_done = w_byte_done;
    assign o_tx        = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Purpose  : Self-checking bench for uart_tx_buffered (CLKS_PER_BIT = 10,
//            FIFO_DEPTH = 16). Honours UART_TX_PARITY_EN for the frame shape.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int c_CLK_FREQ = 1000;
    localparam int c_BAUD     = 100;
    localparam int c_DEPTH    = 16;
    localparam int c_CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int c_NBITS    = 11;
`else
    localparam int c_NBITS    = 10;
`endif
    localparam int c_FL       = c_NBITS * c_CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] fifo_cnt;
    logic       overflow;
    logic       busy;
    logic       byte_done;
    logic       tx;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLK_FREQ   (c_CLK_FREQ),
        .BAUD       (c_BAUD),
        .FIFO_DEPTH (c_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_fifo_cnt  (fifo_cnt),
        .o_overflow  (overflow),
        .o_busy      (busy),
        .o_byte_done (byte_done),
        .o_tx        (tx)
    );

    // Line bits in transmission order: bit 0 = start, then d0..d7,
    // then parity (8E1) or stop (8N1), then stop (8E1 only).
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs [8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int           done_cnt;
        int           done_at;
        int           done_at2;
        int           ov_cnt;
        int           ov_at;
        int           idle_cnt;
        int           low_cnt;
        int           f;
        int           off;
        logic [10:0]  got [17];
        logic [10:0]  expf;
        logic [7:0]   d;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{8'h00, 11'b1_0_00000000_0};
        vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
        vecs[3] = '{8'h01, 11'b1_1_00000001_0};
        vecs[4] = '{8'h80, 11'b1_1_10000000_0};
        vecs[5] = '{8'h3C, 11'b1_0_00111100_0};
        vecs[6] = '{8'h07, 11'b1_1_00000111_0};
        vecs[7] = '{8'h03, 11'b1_0_00000011_0};
`else
        vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
        vecs[1] = '{8'h00, 11'b0_1_00000000_0};
        vecs[2] = '{8'hFF, 11'b0_1_11111111_0};
        vecs[3] = '{8'h01, 11'b0_1_00000001_0};
        vecs[4] = '{8'h80, 11'b0_1_10000000_0};
        vecs[5] = '{8'h3C, 11'b0_1_00111100_0};
        vecs[6] = '{8'h07, 11'b0_1_00000111_0};
        vecs[7] = '{8'h03, 11'b0_1_00000011_0};
`endif

        // ---------------- reset ----------------
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        step(); step(); step();
        check("rst_tx",       tx,        1);
        check("rst_empty",    empty,     1);
        check("rst_full",     full,      0);
        check("rst_cnt",      fifo_cnt,  0);
        check("rst_busy",     busy,      0);
        check("rst_overflow", overflow,  0);
        check("rst_done",     byte_done, 0);
        rst = 1'b0;
        step();
        check("post_rst_tx", tx, 1);

        // ---------------- single-frame table ----------------
        for (int v = 0; v < 8; v++) begin
            wr_en   = 1'b1;
            wr_data = vecs[v].data;
            step();                       // E0
            wr_en   = 1'b0;
            wr_data = ~vecs[v].data;      // must not reach the line
            check($sformatf("v%0d_tx_at_E0", v), tx, 1);
            done_cnt = 0;
            done_at  = -1;
            for (int k = 1; k <= c_FL + 1; k++) begin
                step();
                if (byte_done) begin
                    done_cnt++;
                    done_at = k;
                end
                if (k == 1) check($sformatf("v%0d_start_latency", v), tx, 0);
                if (k % c_CPB == 5)
                    check($sformatf("v%0d_bit%0d", v, k / c_CPB), tx, vecs[v].frame[k / c_CPB]);
            end
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_done_at", v),  done_at,  c_FL);
            check($sformatf("v%0d_busy_after", v), busy, 0);
        end

        // ---------------- 18 writes: fill, overflow, 17 frames ----------------
        ov_cnt   = 0;
        ov_at    = -1;
        done_cnt = 0;
        for (int i = 0; i < 17; i++) got[i] = '0;
        for (int k = 0; k <= 17 * c_FL + 20; k++) begin
            if (k < 18) begin
                wr_en   = 1'b1;
                wr_data = 8'h10 + k[7:0];
            end else begin
                wr_en   = 1'b0;
            end
            step();                       // Ek
            if (overflow) begin
                ov_cnt++;
                ov_at = k;
            end
            if (byte_done) done_cnt++;
            if (k == 1)  check("burst_first_pop_tx", tx, 0);
            if (k == 1)  check("burst_cnt_E1", fifo_cnt, 1);
            if (k == 15) check("burst_full_E15", full, 0);
            if (k == 16) check("burst_full_E16", full, 1);
            if (k == 16) check("burst_cnt_E16", fifo_cnt, 16);
            if (k >= 1) begin
                f   = (k - 1) / c_FL;
                off = (k - 1) % c_FL;
                if (f < 17 && (off % c_CPB) == 4) got[f][off / c_CPB] = tx;
            end
        end
        check("burst_ov_cnt",   ov_cnt,   1);
        check("burst_ov_at",    ov_at,    17);
        check("burst_frames",   done_cnt, 17);
        check("burst_busy_end", busy,     0);
        check("burst_empty",    empty,    1);
        for (int i = 0; i < 17; i++) begin
            d = 8'h10 + i[7:0];
`ifdef UART_TX_PARITY_EN
            expf = {1'b1, ^d, d, 1'b0};
`else
            expf = {1'b0, 1'b1, d, 1'b0};
`endif
            check($sformatf("burst_frame%0d", i), got[i], expf);
        end

        // ---------------- back-to-back 0x00, 0xFF ----------------
        done_at  = -1;
        done_at2 = -1;
        idle_cnt = 0;
        for (int k = 0; k <= 2 * c_FL + 5; k++) begin
            wr_en   = (k < 2);
            wr_data = (k == 0) ? 8'h00 : 8'hFF;
            step();
            if (byte_done) begin
                if (done_at < 0) done_at = k;
                else             done_at2 = k;
            end
            if (k >= 1 && k <= 2 * c_FL && !busy) idle_cnt++;
            if (k == c_FL)          check("b2b_stop_tx", tx, 1);
            if (k == c_FL + 1)      check("b2b_second_start", tx, 0);
            if (k == c_FL + 15)     check("b2b_second_d0", tx, 1);
        end
        check("b2b_done1", done_at,  c_FL);
        check("b2b_done2", done_at2, 2 * c_FL);
        check("b2b_no_idle", idle_cnt, 0);

        // ---------------- reset during DATA of byte 1 ----------------
        done_cnt = 0;
        low_cnt  = 0;
        for (int k = 0; k <= 400; k++) begin
            wr_en   = (k < 3);
            wr_data = 8'h00 + {k[3:0], k[3:0]};
            rst     = (k == 41);
            step();
            if (byte_done) done_cnt++;
            if (k == 40) check("rstmid_data_low", tx, 0);
            if (k == 40) check("rstmid_cnt_before", fifo_cnt, 2);
            if (k == 41) begin
                check("rstmid_tx",    tx,       1);
                check("rstmid_cnt",   fifo_cnt, 0);
                check("rstmid_empty", empty,    1);
                check("rstmid_busy",  busy,     0);
            end
            if (k >= 41 && !tx) low_cnt++;
        end
        rst = 1'b0;
        check("rstmid_no_done", done_cnt, 0);
        check("rstmid_line_idle", low_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
